// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: decodes j/jal, beq/bne and jr $ra, predicts
// branches with a 2-bit saturating counter table and returns with a circular RAS.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int unsigned RAS_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_en,
  input  logic [31:0]                    pc,
  input  logic [31:0]                    instr,
  output logic [31:0]                    pc_plus_4,
  output logic [31:0]                    pc_next,
  output logic                           is_branch,
  output logic                           is_jump,
  output logic                           is_return,
  output logic                           pred_taken,
  output logic [INDEX_BITS-1:0]          pred_index,
  input  logic                           update_en,
  input  logic [INDEX_BITS-1:0]          update_index,
  input  logic                           update_taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int unsigned PHT_SIZE = 1 << INDEX_BITS;
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [4:0] REG_RA     = 5'd31;

  logic [1:0]       pht [PHT_SIZE];
  logic [31:0]      ras [RAS_DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;

  logic [5:0]       op;
  logic [5:0]       func;
  logic [4:0]       rs;
  logic [31:0]      jump_target;
  logic [31:0]      branch_target;
  logic             is_jal;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] tos_inc;
  logic [1:0]       pht_cur;
  logic [1:0]       pht_next;

  assign op        = instr[31:26];
  assign func      = instr[5:0];
  assign rs        = instr[25:21];
  assign pc_plus_4 = pc + 32'd4;
  assign ras_count = count;
  assign pred_index = pc[INDEX_BITS+1:2];

  assign jump_target   = {pc_plus_4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc_plus_4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  // Decode and next-PC selection; all flags default low for non-control instructions
  always_comb begin
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_return  = 1'b0;
    is_jal     = 1'b0;
    pred_taken = 1'b0;
    pc_next    = pc_plus_4;
    if (op == OP_J || op == OP_JAL) begin
      is_jump = 1'b1;
      is_jal  = (op == OP_JAL);
      pc_next = jump_target;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      is_branch  = 1'b1;
      pred_taken = pht[pred_index][1];
      if (pred_taken) pc_next = branch_target;
    end else if (op == OP_SPECIAL && func == FN_JR && rs == REG_RA) begin
      is_return = 1'b1;
      if (count != CNT_W'(0)) pc_next = ras[tos];
    end
  end

  assign push    = fetch_en && is_jal;
  assign pop     = fetch_en && is_return && (count != CNT_W'(0));
  assign tos_inc = tos + PTR_W'(1);

  // Saturating 2-bit counter step for the resolved branch
  always_comb begin
    pht_cur  = pht[update_index];
    pht_next = pht_cur;
    if (update_taken) begin
      if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= INIT_STATE;
    end else if (update_en) begin
      pht[update_index] <= pht_next;
    end
  end

  // Circular RAS: a push when full silently overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= 32'd0;
      tos   <= '0;
      count <= '0;
    end else if (push) begin
      tos          <= tos_inc;
      ras[tos_inc] <= pc_plus_4;
      if (count != CNT_W'(RAS_DEPTH)) count <= count + CNT_W'(1);
    end else if (pop) begin
      tos   <= tos - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: PHT training and saturation, RAS push/pop,
// overflow, fetch gating, same-cycle update and reset priority.
module tb_branch_predictor;

  localparam int unsigned IB = 6;
  localparam int unsigned RD = 8;
  localparam int unsigned CW = $clog2(RD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [31:0]   pc_plus_4;
  logic [31:0]   pc_next;
  logic          is_branch;
  logic          is_jump;
  logic          is_return;
  logic          pred_taken;
  logic [IB-1:0] pred_index;
  logic          update_en;
  logic [IB-1:0] update_index;
  logic          update_taken;
  logic [CW-1:0] ras_count;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.INDEX_BITS(IB), .INIT_STATE(2'b01), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc), .instr(instr),
    .pc_plus_4(pc_plus_4), .pc_next(pc_next), .is_branch(is_branch),
    .is_jump(is_jump), .is_return(is_return), .pred_taken(pred_taken),
    .pred_index(pred_index), .update_en(update_en), .update_index(update_index),
    .update_taken(update_taken), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_beq(input logic [15:0] imm);
    return {6'b000100, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [31:0] tgt);
    return {6'b000011, tgt[27:2]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] tgt);
    return {6'b000010, tgt[27:2]};
  endfunction

  function automatic logic [31:0] enc_jr(input logic [4:0] rs);
    return {6'b000000, rs, 15'd0, 6'b001000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic train(input logic [IB-1:0] idx, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      update_en = 1'b1; update_index = idx; update_taken = taken;
      tick();
    end
    update_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pc = 32'h0040_0000; instr = 32'h0022_1820;  // add $3,$1,$2
    #1;
    checks++; if (ras_count !== CW'(0)) begin errors++; $display("FAIL reset_ras_count got %0d exp 0", ras_count); end
    checks++; if ({is_branch, is_jump, is_return, pred_taken} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {is_branch, is_jump, is_return, pred_taken}); end
    checks++; if (pc_next !== 32'h0040_0004) begin errors++; $display("FAIL alu_pc_next got %h exp 00400004", pc_next); end
    checks++; if (pc_plus_4 !== 32'h0040_0004) begin errors++; $display("FAIL pc_plus_4 got %h exp 00400004", pc_plus_4); end
  endtask

  task automatic test_branch_train();
    pc = 32'h0040_0010; instr = enc_beq(16'h0004);
    #1;
    checks++; if (pred_index !== 6'd4) begin errors++; $display("FAIL beq_index got %0d exp 4", pred_index); end
    checks++; if (is_branch !== 1'b1 || pred_taken !== 1'b0) begin errors++; $display("FAIL beq_init got br=%b tk=%b exp br=1 tk=0", is_branch, pred_taken); end
    checks++; if (pc_next !== 32'h0040_0014) begin errors++; $display("FAIL beq_init_next got %h exp 00400014", pc_next); end
    train(6'd4, 1'b1, 3);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_trained_taken got %b exp 1", pred_taken); end
    checks++; if (pc_next !== 32'h0040_0024) begin errors++; $display("FAIL beq_trained_next got %h exp 00400024", pc_next); end
  endtask

  task automatic test_saturation();
    pc = 32'h0040_0024; instr = {6'b000101, 10'd0, 16'hFFFF};  // bne, index 9, target = pc
    train(6'd9, 1'b1, 5);
    train(6'd9, 1'b0, 1);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_10_taken got %b exp 1", pred_taken); end
    checks++; if (pc_next !== 32'h0040_0024) begin errors++; $display("FAIL sat_10_next got %h exp 00400024", pc_next); end
    train(6'd9, 1'b0, 1);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_01_taken got %b exp 0", pred_taken); end
    checks++; if (pc_next !== 32'h0040_0028) begin errors++; $display("FAIL sat_01_next got %h exp 00400028", pc_next); end
    train(6'd9, 1'b0, 4);
    train(6'd9, 1'b1, 1);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low_taken got %b exp 0", pred_taken); end
  endtask

  task automatic test_jump();
    pc = 32'h1FFF_FFF0; instr = enc_j(32'h0000_0100);
    #1;
    checks++; if (is_jump !== 1'b1 || is_branch !== 1'b0) begin errors++; $display("FAIL j_flags got j=%b b=%b exp j=1 b=0", is_jump, is_branch); end
    checks++; if (pc_next !== 32'h1000_0100) begin errors++; $display("FAIL j_target got %h exp 10000100", pc_next); end
  endtask

  task automatic test_call_return();
    pc = 32'h0040_0100; instr = enc_jal(32'h0040_0200); fetch_en = 1'b1;
    #1;
    checks++; if (pc_next !== 32'h0040_0200 || is_jump !== 1'b1) begin errors++; $display("FAIL jal_next got %h j=%b exp 00400200 j=1", pc_next, is_jump); end
    tick();
    checks++; if (ras_count !== CW'(1)) begin errors++; $display("FAIL jal_count got %0d exp 1", ras_count); end
    pc = 32'h0040_0300; instr = enc_jr(5'd31);
    #1;
    checks++; if (is_return !== 1'b1 || pc_next !== 32'h0040_0104) begin errors++; $display("FAIL ret_next got %h r=%b exp 00400104 r=1", pc_next, is_return); end
    tick();
    checks++; if (ras_count !== CW'(0)) begin errors++; $display("FAIL ret_count got %0d exp 0", ras_count); end
    checks++; if (pc_next !== 32'h0040_0304) begin errors++; $display("FAIL ret_empty_next got %h exp 00400304", pc_next); end
    tick();
    checks++; if (ras_count !== CW'(0)) begin errors++; $display("FAIL ret_empty_count got %0d exp 0", ras_count); end
    fetch_en = 1'b0;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_next;
    int          exp_cnt;
    fetch_en = 1'b1;
    for (int i = 0; i < RD + 2; i++) begin
      pc = 32'h0040_1000 + 32'(i * 16); instr = enc_jal(32'h0040_8000);
      tick();
      exp_cnt = (i + 1 > RD) ? RD : i + 1;
      checks++; if (ras_count !== CW'(exp_cnt)) begin errors++; $display("FAIL push_count[%0d] got %0d exp %0d", i, ras_count, exp_cnt); end
    end
    for (int j = 0; j < RD + 2; j++) begin
      pc = 32'h0040_2000 + 32'(j * 16); instr = enc_jr(5'd31);
      #1;
      exp_next = (j < RD) ? 32'h0040_1000 + 32'((RD + 1 - j) * 16) + 32'd4 : pc + 32'd4;
      checks++; if (pc_next !== exp_next) begin errors++; $display("FAIL pop_next[%0d] got %h exp %h", j, pc_next, exp_next); end
      tick();
      exp_cnt = (j < RD) ? RD - 1 - j : 0;
      checks++; if (ras_count !== CW'(exp_cnt)) begin errors++; $display("FAIL pop_count[%0d] got %0d exp %0d", j, ras_count, exp_cnt); end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_fetch_gate();
    fetch_en = 1'b0; pc = 32'h0040_0500; instr = enc_jal(32'h0040_0600);
    tick();
    checks++; if (ras_count !== CW'(0)) begin errors++; $display("FAIL gated_jal_count got %0d exp 0", ras_count); end
    checks++; if (pc_next !== 32'h0040_0600) begin errors++; $display("FAIL gated_jal_next got %h exp 00400600", pc_next); end
    fetch_en = 1'b1; instr = enc_jr(5'd8);
    #1;
    checks++; if (is_return !== 1'b0 || pc_next !== 32'h0040_0504) begin errors++; $display("FAIL jr_t0 got r=%b next=%h exp r=0 next=00400504", is_return, pc_next); end
    fetch_en = 1'b0;
  endtask

  task automatic test_same_cycle_and_reset();
    pc = 32'h0040_0030; instr = enc_beq(16'h0010);  // index 12
    update_en = 1'b1; update_index = 6'd12; update_taken = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bypass_old got %b exp 0", pred_taken); end
    tick();
    update_en = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1 || pc_next !== 32'h0040_0074) begin errors++; $display("FAIL bypass_new got tk=%b next=%h exp tk=1 next=00400074", pred_taken, pc_next); end
    fetch_en = 1'b1; instr = enc_jal(32'h0040_0800);
    tick();
    fetch_en = 1'b0;
    instr = enc_beq(16'h0010);
    reset = 1'b1; update_en = 1'b1; update_index = 6'd12; update_taken = 1'b1;
    tick();
    reset = 1'b0; update_en = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_vs_update got %b exp 0", pred_taken); end
    checks++; if (ras_count !== CW'(0)) begin errors++; $display("FAIL reset_ras got %0d exp 0", ras_count); end
    pc = 32'h0040_0010; instr = enc_beq(16'h0004);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_idx4 got %b exp 0", pred_taken); end
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0; pc = '0; instr = '0;
    update_en = 1'b0; update_index = '0; update_taken = 1'b0;
    test_reset();
    test_branch_train();
    test_saturation();
    test_jump();
    test_call_return();
    test_ras_overflow();
    test_fetch_gate();
    test_same_cycle_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
